// File: rtl/io_hex_display.sv
// Display driver for eight active-low seven-segment digits fed from a CPU output word.
// Converts each captured word to hex or decimal (serial double-dabble) digits.
module io_hex_display #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  input  logic             mode_dec,
  output logic [55:0]      hex_out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned BcdW = 40;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StConv, StOut} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic             dec_q;
  logic [BcdW-1:0]  bcd_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] pend_word_q;
  logic             pend_dec_q;
  logic             pend_vld_q;
  logic [55:0]      hex_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic [BcdW-1:0]  bcd_adj;
  logic [BcdW-1:0]  bcd_next;
  logic [55:0]      seg_d;
  logic             ovf_d;
  logic             seen;
  logic [3:0]       digit;
  logic [WIDTH-1:0] take_word;
  logic             take_dec;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Double-dabble step: correct every BCD nibble >= 5 before shifting in the next MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < 10; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_next = (bcd_adj << 1) | {{(BcdW-1){1'b0}}, word_q[WIDTH-1]};
  end

  // Segment pattern for the word currently held; only registered on the OUT edge.
  always_comb begin
    seen  = 1'b0;
    digit = 4'h0;
    seg_d = '1;
    ovf_d = dec_q & (|bcd_q[BcdW-1:32]);
    for (int i = 7; i >= 0; i--) begin
      digit = dec_q ? bcd_q[4*i +: 4] : word_q[4*i +: 4];
      seen  = seen | (digit != 4'h0);
      if (ovf_d)                             seg_d[7*i +: 7] = 7'h3F;
      else if (LZ_BLANK && !seen && (i != 0)) seg_d[7*i +: 7] = 7'h7F;
      else                                   seg_d[7*i +: 7] = seg7(digit);
    end
  end

  // A load coinciding with the OUT edge is newer than the pending slot.
  assign take_word = load ? value    : pend_word_q;
  assign take_dec  = load ? mode_dec : pend_dec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_q      <= '0;
      dec_q       <= 1'b0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      pend_word_q <= '0;
      pend_dec_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      hex_q       <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load) begin
            word_q  <= value;
            dec_q   <= mode_dec;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= mode_dec ? StConv : StOut;
          end
        end
        StConv: begin
          if (load) begin
            pend_word_q <= value;
            pend_dec_q  <= mode_dec;
            pend_vld_q  <= 1'b1;
          end
          bcd_q  <= bcd_next;
          word_q <= word_q << 1;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StOut;
        end
        StOut: begin
          hex_q  <= seg_d;
          ovf_q  <= ovf_d;
          done_q <= 1'b1;
          if (load || pend_vld_q) begin
            word_q     <= take_word;
            dec_q      <= take_dec;
            bcd_q      <= '0;
            cnt_q      <= '0;
            pend_vld_q <= 1'b0;
            state_q    <= take_dec ? StConv : StOut;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hex_out  = hex_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_io_hex_display.sv
// Self-checking bench for io_hex_display: directed scenarios plus randomized words
// compared against an arithmetic (divide/modulo) display model.
module tb_io_hex_display;

  localparam int unsigned Width = 32;

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic        load;
  logic        mode_dec;
  logic [55:0] hex_out;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] SegTab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  io_hex_display #(
    .WIDTH    (Width),
    .LZ_BLANK (1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .mode_dec (mode_dec),
    .hex_out  (hex_out),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_ovf(input logic [31:0] v, input logic dec);
    return dec && (v > 32'd99_999_999);
  endfunction

  function automatic logic [55:0] model_seg(input logic [31:0] v, input logic dec);
    logic [3:0]      d [8];
    logic [55:0]     r;
    longint unsigned x;
    int              hi;
    if (model_ovf(v, dec)) return {8{7'h3F}};
    x = longint'(v);
    for (int i = 0; i < 8; i++) begin
      if (dec) begin
        d[i] = 4'(x % 10);
        x    = x / 10;
      end else begin
        d[i] = v[4*i +: 4];
      end
    end
    hi = 0;
    for (int i = 0; i < 8; i++) if (d[i] != 4'h0) hi = i;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = (i > hi) ? 7'h7F : SegTab[d[i]];
    return r;
  endfunction

  // Returns one ns after the capture edge, with load already dropped.
  task automatic start_load(input logic [31:0] v, input logic dec);
    @(negedge clk);
    value    = v;
    mode_dec = dec;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (hex_out !== {56{1'b1}}) begin
      failures++; $display("FAIL reset_hex: got %h expected %h", hex_out, {56{1'b1}});
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hex;
    int          cyc;
    logic [55:0] exp_hex;
    exp_hex = {{6{7'h7F}}, 7'h08, 7'h24};
    start_load(32'h0000_00A2, 1'b0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL hex_busy_start: got busy=%b done=%b expected 1/0", busy, done);
    end
    wait_done(10, cyc);
    checks++;
    if (cyc != 1) begin failures++; $display("FAIL hex_latency: got %0d expected 1", cyc); end
    checks++;
    if (hex_out !== exp_hex) begin
      failures++; $display("FAIL hex_value: got %h expected %h", hex_out, exp_hex);
    end
    checks++;
    if (busy !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL hex_flags: got busy=%b ovf=%b expected 0/0", busy, overflow);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL hex_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_decimal;
    int          cyc;
    logic [55:0] prior;
    logic [55:0] exp_hex;
    bit          bad;
    prior = hex_out;
    bad   = 1'b0;
    exp_hex = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    start_load(32'd12_345_678, 1'b1);
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk);
      #1;
      if (hex_out !== prior || busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL dec_hold: got change/idle during conversion expected hold"); end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL dec_latency: got done=%b busy=%b expected 1/0 at t+33", done, busy);
    end
    checks++;
    if (hex_out !== exp_hex || overflow !== 1'b0) begin
      failures++; $display("FAIL dec_value: got %h ovf=%b expected %h ovf=0", hex_out, overflow, exp_hex);
    end
    start_load(32'd2, 1'b1);
    wait_done(Width + 5, cyc);
    checks++;
    if (cyc != int'(Width) + 1 || hex_out !== {{7{7'h7F}}, 7'h24}) begin
      failures++; $display("FAIL dec_small: got cyc=%0d hex=%h expected %0d %h", cyc, hex_out,
                           Width + 1, {{7{7'h7F}}, 7'h24});
    end
  endtask

  task automatic test_overflow;
    int cyc;
    start_load(32'hFFFF_FFFF, 1'b1);
    wait_done(Width + 5, cyc);
    checks++;
    if (hex_out !== {8{7'h3F}} || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_max: got %h ovf=%b expected %h ovf=1", hex_out, overflow, {8{7'h3F}});
    end
    start_load(32'd0, 1'b0);
    wait_done(10, cyc);
    checks++;
    if (hex_out !== {{7{7'h7F}}, 7'h40} || overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear: got %h ovf=%b expected %h ovf=0", hex_out, overflow,
                           {{7{7'h7F}}, 7'h40});
    end
    start_load(32'd99_999_999, 1'b1);
    wait_done(Width + 5, cyc);
    checks++;
    if (hex_out !== {8{7'h10}} || overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_edge_low: got %h ovf=%b expected %h ovf=0", hex_out, overflow, {8{7'h10}});
    end
    start_load(32'd100_000_000, 1'b1);
    wait_done(Width + 5, cyc);
    checks++;
    if (hex_out !== {8{7'h3F}} || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_edge_high: got %h ovf=%b expected %h ovf=1", hex_out, overflow, {8{7'h3F}});
    end
  endtask

  task automatic test_back_to_back;
    int         ndone;
    int         first_at;
    logic [6:0] first_hex0;
    bit         gap;
    ndone = 0; first_at = -1; first_hex0 = 7'h7F; gap = 1'b0;
    start_load(32'd5, 1'b1);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      load = 1'b0;
      if (n == 5)  begin value = 32'd7; mode_dec = 1'b1; load = 1'b1; end
      if (n == 12) begin value = 32'd9; mode_dec = 1'b0; load = 1'b1; end
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin first_at = n; first_hex0 = hex_out[6:0]; end
      end
      if (n < 34 && busy !== 1'b1) gap = 1'b1;
    end
    load = 1'b0;
    checks++;
    if (ndone != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    checks++;
    if (first_at != 33 || first_hex0 !== 7'h12) begin
      failures++; $display("FAIL b2b_first: got at=%0d hex0=%h expected 33 12", first_at, first_hex0);
    end
    checks++;
    if (hex_out !== model_seg(32'd9, 1'b0) || busy !== 1'b0) begin
      failures++; $display("FAIL b2b_final: got %h busy=%b expected %h busy=0", hex_out, busy,
                           model_seg(32'd9, 1'b0));
    end
    checks++;
    if (gap) begin failures++; $display("FAIL b2b_busy: got busy gap expected continuous busy"); end
  endtask

  task automatic test_reset_mid;
    bit bad;
    bad = 1'b0;
    start_load($urandom, 1'b1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      load = 1'b0;
      if (n == 5) begin value = $urandom; mode_dec = 1'b0; load = 1'b1; end
    end
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hex_out !== {56{1'b1}} || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_reset: got hex=%h busy=%b done=%b ovf=%b expected blank/0/0/0",
                           hex_out, busy, done, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || hex_out !== {56{1'b1}}) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL mid_after: got activity after reset expected quiet blank"); end
  endtask

  task automatic test_random;
    int          cyc;
    logic [31:0] v;
    logic        dec;
    for (int it = 0; it < 24; it++) begin
      v = $urandom;
      case ($urandom_range(0, 3))
        0: v = v % 32'd100_000_000;
        1: v = v >> $urandom_range(4, 28);
        2: v = v % 32'd1000;
        default: ;
      endcase
      dec = 1'($urandom_range(0, 1));
      start_load(v, dec);
      wait_done(Width + 5, cyc);
      checks++;
      if (cyc != (dec ? int'(Width) + 1 : 1)) begin
        failures++; $display("FAIL rand_latency: v=%h dec=%b got %0d expected %0d", v, dec, cyc,
                             dec ? Width + 1 : 1);
      end
      checks++;
      if (hex_out !== model_seg(v, dec) || overflow !== model_ovf(v, dec)) begin
        failures++; $display("FAIL rand_value: v=%h dec=%b got %h ovf=%b expected %h ovf=%b", v, dec,
                             hex_out, overflow, model_seg(v, dec), model_ovf(v, dec));
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    value    = '0;
    load     = 1'b0;
    mode_dec = 1'b0;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
